// File: rtl/tx_sched_pkg.sv
// Shared source indices, FSM encoding and frame sizing for the UART TX scheduler.
// TX_CHECKSUM_EN widens each frame by one XOR checksum byte.
package tx_sched_pkg;

  localparam int NUM_SRC = 3;

  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_ALU = 2'd1;
  localparam logic [1:0] SRC_ERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

`ifdef TX_CHECKSUM_EN
  localparam int MAX_FRAME_BYTES = 3;
`else
  localparam int MAX_FRAME_BYTES = 2;
`endif

  localparam int IDX_W = $clog2(MAX_FRAME_BYTES);

  // Successor of a source in the RF -> ALU -> ERR -> RF ring.
  function automatic logic [1:0] rr_next(input logic [1:0] src);
    return (src == SRC_ERR) ? SRC_RF : src + 2'd1;
  endfunction

endpackage

// File: rtl/tx_rr_arbiter.sv
// Three-way round-robin arbiter: search starts at the pointer, which moves one
// past the winner whenever a grant is actually issued.
module tx_rr_arbiter
  import tx_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] pending,
  input  logic               grant_en,
  output logic [NUM_SRC-1:0] grant
);

  logic [1:0] ptr;
  logic [1:0] ptr_next;
  logic [1:0] cand;
  logic [1:0] win;
  logic       found;

  always_comb begin
    grant    = '0;
    win      = ptr;
    found    = 1'b0;
    cand     = ptr;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!found && pending[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = rr_next(cand);
    end
    if (grant_en && found) begin
      grant[win] = 1'b1;
    end
    ptr_next = (grant_en && found) ? rr_next(win) : ptr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= SRC_RF;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX serializer among RF, ALU and error frame sources.
// Define TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rf_req,
  input  logic [DATA_W-1:0]   rf_data,
  input  logic                alu_req,
  input  logic [2*DATA_W-1:0] alu_data,
  input  logic                err_req,
  input  logic [DATA_W-1:0]   err_data,
  input  logic                clr_ovf,
  input  logic                uart_busy,
  output logic [DATA_W-1:0]   tx_p_data,
  output logic                tx_valid,
  output logic                frame_done,
  output logic                tx_timeout,
  output logic [2:0]          ovf,
  output logic                sched_busy
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  state_t state;
  state_t state_next;

  logic                  rf_pend, alu_pend, err_pend;
  logic [DATA_W-1:0]     rf_slot, err_slot;
  logic [2*DATA_W-1:0]   alu_slot;
  logic [NUM_SRC-1:0]    pending, grant, drop;
  logic                  grant_en;

  logic [MAX_FRAME_BYTES-1:0][DATA_W-1:0] frame_buf, load_buf;
  logic [IDX_W-1:0]      frame_last, load_last, idx;
  logic [TO_W-1:0]       to_cnt;
  logic                  done_next, timeout_next;

  assign pending    = {err_pend, alu_pend, rf_pend};
  assign grant_en   = (state == IDLE);
  assign sched_busy = (state != IDLE);

  tx_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .pending  (pending),
    .grant_en (grant_en),
    .grant    (grant)
  );

  // A full slot only accepts a new request in the cycle it is being granted.
  assign drop = {err_req & err_pend & ~grant[SRC_ERR],
                 alu_req & alu_pend & ~grant[SRC_ALU],
                 rf_req  & rf_pend  & ~grant[SRC_RF]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_pend  <= 1'b0;
      alu_pend <= 1'b0;
      err_pend <= 1'b0;
      rf_slot  <= '0;
      alu_slot <= '0;
      err_slot <= '0;
      ovf      <= '0;
    end else begin
      if (rf_req && (!rf_pend || grant[SRC_RF])) begin
        rf_pend <= 1'b1;
        rf_slot <= rf_data;
      end else if (grant[SRC_RF]) begin
        rf_pend <= 1'b0;
      end
      if (alu_req && (!alu_pend || grant[SRC_ALU])) begin
        alu_pend <= 1'b1;
        alu_slot <= alu_data;
      end else if (grant[SRC_ALU]) begin
        alu_pend <= 1'b0;
      end
      if (err_req && (!err_pend || grant[SRC_ERR])) begin
        err_pend <= 1'b1;
        err_slot <= err_data;
      end else if (grant[SRC_ERR]) begin
        err_pend <= 1'b0;
      end
      ovf <= drop | (ovf & ~{NUM_SRC{clr_ovf}});
    end
  end

  // Frame image for the granted source; ALU goes out low byte first.
  always_comb begin
    load_buf  = '0;
    load_last = '0;
    if (grant[SRC_ALU]) begin
      load_buf[0] = alu_slot[DATA_W-1:0];
      load_buf[1] = alu_slot[2*DATA_W-1:DATA_W];
      load_last   = IDX_W'(1);
    end else if (grant[SRC_ERR]) begin
      load_buf[0] = err_slot;
    end else begin
      load_buf[0] = rf_slot;
    end
`ifdef TX_CHECKSUM_EN
    load_last           = load_last + IDX_W'(1);
    load_buf[load_last] = load_buf[0] ^ load_buf[1];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    tx_valid     = 1'b0;
    tx_p_data    = '0;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    case (state)
      IDLE: begin
        if (|pending) begin
          state_next = SEND;
        end
      end
      SEND: begin
        tx_valid  = 1'b1;
        tx_p_data = frame_buf[idx];
        if (uart_busy) begin
          state_next = WAIT_DONE;
        end else if ((ACK_TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          if (idx == frame_last) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame bookkeeping and the saturating acknowledge timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_buf  <= '0;
      frame_last <= '0;
      idx        <= '0;
      to_cnt     <= '0;
      frame_done <= 1'b0;
      tx_timeout <= 1'b0;
    end else begin
      frame_done <= done_next;
      tx_timeout <= timeout_next;
      if (|grant) begin
        frame_buf  <= load_buf;
        frame_last <= load_last;
        idx        <= '0;
      end else if (state == WAIT_DONE && state_next == SEND) begin
        idx <= idx + IDX_W'(1);
      end
      if (state_next == SEND && state != SEND) begin
        to_cnt <= '0;
      end else if (state == SEND && to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: vector table, hand-written corner sequences and a
// byte scoreboard fed by a behavioural UART; expects checksum bytes under TX_CHECKSUM_EN.
module tb_uart_tx_scheduler;
  import tx_sched_pkg::*;

  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 8;
  localparam int TO_W        = 8;
  localparam int BUSY_LEN    = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                rf_req = 1'b0, alu_req = 1'b0, err_req = 1'b0, clr_ovf = 1'b0;
  logic [DATA_W-1:0]   rf_data = '0, err_data = '0;
  logic [2*DATA_W-1:0] alu_data = '0;
  logic                uart_busy = 1'b0;
  logic [DATA_W-1:0]   tx_p_data;
  logic                tx_valid, frame_done, tx_timeout, sched_busy;
  logic [2:0]          ovf;

  int checks = 0;
  int passes = 0;

  logic [7:0] exp_q[$];
  bit model_en = 1'b1;
  int busy_cnt = 0;
  bit armed = 1'b0;
  int cap_cnt = 0;
  int busy_valid_err = 0;

  uart_tx_scheduler #(
    .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .rf_req(rf_req), .rf_data(rf_data),
    .alu_req(alu_req), .alu_data(alu_data),
    .err_req(err_req), .err_data(err_data),
    .clr_ovf(clr_ovf), .uart_busy(uart_busy),
    .tx_p_data(tx_p_data), .tx_valid(tx_valid),
    .frame_done(frame_done), .tx_timeout(tx_timeout),
    .ovf(ovf), .sched_busy(sched_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // UART model: takes a byte when valid is seen, raises busy one cycle later for BUSY_LEN cycles.
  always @(negedge clk) begin
    if (!rst || !model_en) begin
      uart_busy = 1'b0;
      busy_cnt  = 0;
      armed     = 1'b0;
    end else if (busy_cnt > 0) begin
      if (tx_valid) busy_valid_err++;
      busy_cnt--;
      if (busy_cnt == 0) uart_busy = 1'b0;
    end else if (armed) begin
      armed     = 1'b0;
      uart_busy = 1'b1;
      busy_cnt  = BUSY_LEN;
    end else if (tx_valid) begin
      cap_cnt++;
      armed = 1'b1;
      if (exp_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL byte_order: got 0x%0h, expected no byte", tx_p_data);
      end else begin
        checkOutput("byte_order", 32'(tx_p_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic pushBytes(input int n, input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0);
    if (n == 2) exp_q.push_back(b1);
`ifdef TX_CHECKSUM_EN
    exp_q.push_back((n == 2) ? (b0 ^ b1) : b0);
`endif
  endtask

  // Drives one cycle of request/clear inputs starting at the current falling edge.
  task automatic applyStimulus(input logic [2:0] req, input logic [7:0] rd,
                               input logic [15:0] ad, input logic [7:0] ed, input logic clr);
    {err_req, alu_req, rf_req} = req;
    rf_data  = rd;
    alu_data = ad;
    err_data = ed;
    clr_ovf  = clr;
    @(negedge clk);
    {err_req, alu_req, rf_req} = 3'b000;
    clr_ovf = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b0;
    {err_req, alu_req, rf_req} = 3'b000;
    clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      seen = frame_done;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic waitValid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = tx_valid;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  typedef struct {
    logic [1:0]  src;
    logic [15:0] data;
    int          nbytes;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int start;
    bit busy_seen;
    logic [7:0] first_data;

    vecs[0] = '{src: SRC_RF,  data: 16'h00A5, nbytes: 1, b0: 8'hA5, b1: 8'h00};
    vecs[1] = '{src: SRC_ALU, data: 16'h1234, nbytes: 2, b0: 8'h34, b1: 8'h12};
    vecs[2] = '{src: SRC_ERR, data: 16'h005C, nbytes: 1, b0: 8'h5C, b1: 8'h00};
    vecs[3] = '{src: SRC_ALU, data: 16'hFF00, nbytes: 2, b0: 8'h00, b1: 8'hFF};
    vecs[4] = '{src: SRC_RF,  data: 16'h0000, nbytes: 1, b0: 8'h00, b1: 8'h00};

    repeat (2) @(negedge clk);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'd0);
    checkOutput("reset_tx_p_data", 32'(tx_p_data), 32'd0);
    checkOutput("reset_flags", 32'({frame_done, tx_timeout, sched_busy}), 32'd0);
    checkOutput("reset_ovf", 32'(ovf), 32'd0);
    applyReset();

    for (int v = 0; v < 5; v++) begin
      pushBytes(vecs[v].nbytes, vecs[v].b0, vecs[v].b1);
      applyStimulus(3'(3'b001 << vecs[v].src), vecs[v].data[7:0], vecs[v].data,
                    vecs[v].data[7:0], 1'b0);
      checkOutput($sformatf("v%0d_valid_n1", v), 32'(tx_valid), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_valid_n2", v), 32'(tx_valid), 32'd1);
      checkOutput($sformatf("v%0d_busy_n2", v), 32'(sched_busy), 32'd1);
      waitDone($sformatf("v%0d_frame_done", v));
      checkOutput($sformatf("v%0d_idle", v), 32'(sched_busy), 32'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_pulse", v), 32'(frame_done), 32'd0);
      checkOutput($sformatf("v%0d_queue", v), 32'(exp_q.size()), 32'd0);
      checkOutput($sformatf("v%0d_ovf", v), 32'(ovf), 32'd0);
    end

    // Simultaneous requests after reset, then an ALU frame moves the pointer to ERR.
    applyReset();
    pushBytes(1, 8'h11, 8'h00);
    pushBytes(2, 8'h22, 8'h33);
    pushBytes(1, 8'h44, 8'h00);
    applyStimulus(3'b111, 8'h11, 16'h3322, 8'h44, 1'b0);
    waitDone("rr_rf_done");
    waitDone("rr_alu_done");
    waitDone("rr_err_done");
    pushBytes(2, 8'h55, 8'h66);
    applyStimulus(3'b010, 8'h00, 16'h6655, 8'h00, 1'b0);
    waitDone("rr_alu2_done");
    pushBytes(1, 8'h88, 8'h00);
    pushBytes(1, 8'h77, 8'h00);
    applyStimulus(3'b101, 8'h77, 16'h0000, 8'h88, 1'b0);
    waitDone("rr_err2_done");
    waitDone("rr_rf2_done");
    @(negedge clk);
    checkOutput("rr_queue", 32'(exp_q.size()), 32'd0);

    // Slot holding, overflow, clear, grant-cycle acceptance and set-over-clear.
    pushBytes(2, 8'h11, 8'h11);
    applyStimulus(3'b010, 8'h00, 16'h1111, 8'h00, 1'b0);
    waitValid("ovf_first_valid");
    pushBytes(2, 8'h22, 8'h22);
    applyStimulus(3'b010, 8'h00, 16'h2222, 8'h00, 1'b0);
    checkOutput("ovf_held", 32'(ovf), 32'd0);
    applyStimulus(3'b010, 8'h00, 16'h3333, 8'h00, 1'b0);
    checkOutput("ovf_set", 32'(ovf), 32'b010);
    applyStimulus(3'b000, 8'h00, 16'h0000, 8'h00, 1'b1);
    checkOutput("ovf_clr", 32'(ovf), 32'd0);
    waitDone("ovf_frame1_done");
    pushBytes(2, 8'h44, 8'h44);
    applyStimulus(3'b010, 8'h00, 16'h4444, 8'h00, 1'b0);
    checkOutput("ovf_grant_cycle", 32'(ovf), 32'd0);
    applyStimulus(3'b010, 8'h00, 16'h5555, 8'h00, 1'b1);
    checkOutput("ovf_set_wins", 32'(ovf), 32'b010);
    applyStimulus(3'b000, 8'h00, 16'h0000, 8'h00, 1'b1);
    checkOutput("ovf_clr2", 32'(ovf), 32'd0);
    waitDone("ovf_frame2_done");
    waitDone("ovf_frame3_done");
    @(negedge clk);
    checkOutput("ovf_queue", 32'(exp_q.size()), 32'd0);

    // Acknowledge timeout with busy held low; the second pending slot follows.
    applyReset();
    model_en = 1'b0;
    applyStimulus(3'b101, 8'h77, 16'h0000, 8'h88, 1'b0);
    for (int f = 0; f < 2; f++) begin
      waitValid($sformatf("to%0d_valid", f));
      first_data = tx_p_data;
      n = 0;
      while (tx_valid && n < 50) begin
        n++;
        @(negedge clk);
      end
      checkOutput($sformatf("to%0d_valid_cycles", f), 32'(n), 32'd8);
      checkOutput($sformatf("to%0d_pulse", f), 32'(tx_timeout), 32'd1);
      checkOutput($sformatf("to%0d_idle", f), 32'(sched_busy), 32'd0);
      checkOutput($sformatf("to%0d_data", f), 32'(first_data), (f == 0) ? 32'h77 : 32'h88);
    end
    @(negedge clk);
    checkOutput("to_pulse_end", 32'(tx_timeout), 32'd0);
    checkOutput("to_no_done", 32'(frame_done), 32'd0);
    model_en = 1'b1;

    // Reset during the second ALU byte with an RF request still queued.
    applyReset();
    exp_q.push_back(8'hEF);
    exp_q.push_back(8'hBE);
    start = cap_cnt;
    applyStimulus(3'b010, 8'h00, 16'hBEEF, 8'h00, 1'b0);
    applyStimulus(3'b001, 8'h99, 16'h0000, 8'h00, 1'b0);
    for (int i = 0; i < 100 && cap_cnt < start + 2; i++) @(negedge clk);
    checkOutput("rst_mid_bytes", 32'(cap_cnt - start), 32'd2);
    checkOutput("rst_mid_valid", 32'(tx_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(tx_valid), 32'd0);
    checkOutput("rst_async_data", 32'(tx_p_data), 32'd0);
    checkOutput("rst_async_flags", 32'({frame_done, tx_timeout, sched_busy, ovf}), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    busy_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      busy_seen |= sched_busy | tx_valid;
    end
    checkOutput("rst_slots_empty", 32'(busy_seen), 32'd0);
    checkOutput("rst_queue", 32'(exp_q.size()), 32'd0);
    checkOutput("valid_low_while_busy", 32'(busy_valid_err), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
